// File: rtl/mcc_pkg.sv
// Shared types and encodings for the multicycle MIPS control path:
// FSM states, opcode/funct fields, ALU-op classes and ALU control codes.
package mcc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEXEC,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control-path bundle between the multicycle controller (master) and the
// datapath (slave): instruction fields and status in, enables and selects out.
interface multicycle_controller_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;

    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal;

    modport master (
        input  op, funct, zero, memready,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal
    );

    modport slave (
        output op, funct, zero, memready,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal
    );

endinterface

// File: rtl/alu_decoder.sv
// ALU decoder: maps the controller's ALU-op class and the R-type funct field
// to the 3-bit ALU operation. Shared with the single-cycle control path.
module alu_decoder
    import mcc_pkg::*;
(
    input  aluop_t     i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    F_ADD:   o_alucontrol = ALU_ADD;
                    F_SUB:   o_alucontrol = ALU_SUB;
                    F_AND:   o_alucontrol = ALU_AND;
                    F_OR:    o_alucontrol = ALU_OR;
                    F_SLT:   o_alucontrol = ALU_SLT;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath (lw/sw/R-type/beq/addi/j).
// Memory-access states stall on memready; unsupported opcodes pulse illegal.
module multicycle_controller
    import mcc_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    state_t     r_state;
    state_t     w_next_state;
    aluop_t     w_aluop;
    logic       w_mem_ok;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_iord;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    logic       w_illegal;

    assign w_mem_ok = MEM_WAIT_EN ? bus.memready : 1'b1;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of process evaluation order.
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_next_state = r_state;
        w_aluop      = ALUOP_ADD;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_iord       = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b0;
        w_regwrite   = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_pcsrc      = 2'b00;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alusrcb = 2'b01;
                w_irwrite = w_mem_ok;
                w_pcwrite = w_mem_ok;
                if (w_mem_ok) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEXEC;
                    OP_J:         w_next_state = S_JUMP;
                    default: begin
                        w_illegal    = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_next_state = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                if (w_mem_ok) w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_memtoreg   = 1'b1;
                w_regwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                if (w_mem_ok) w_next_state = S_FETCH;
            end
            S_EXECUTE: begin
                w_alusrca    = 1'b1;
                w_aluop      = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_regdst     = 1'b1;
                w_regwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_alusrca    = 1'b1;
                w_aluop      = ALUOP_SUB;
                w_pcsrc      = 2'b01;
                w_branch     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_ADDIEXEC: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                w_pcsrc      = 2'b10;
                w_pcwrite    = 1'b1;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct      (bus.funct),
        .o_alucontrol (bus.alucontrol)
    );

    // Write strobes are suppressed for the whole reset cycle, whatever the state.
    assign bus.iord     = w_iord;
    assign bus.memwrite = w_memwrite & ~reset;
    assign bus.irwrite  = w_irwrite & ~reset;
    assign bus.regdst   = w_regdst;
    assign bus.memtoreg = w_memtoreg;
    assign bus.regwrite = w_regwrite & ~reset;
    assign bus.alusrca  = w_alusrca;
    assign bus.alusrcb  = w_alusrcb;
    assign bus.pcsrc    = w_pcsrc;
    assign bus.pcen     = (w_pcwrite | (w_branch & bus.zero)) & ~reset;
    assign bus.illegal  = w_illegal & ~reset;

endmodule
